// File: rtl/riscv_hwloop_regs_pkg.sv
// Shared types and write-enable bit positions for the hardware-loop register file.
package riscv_hwloop_pkg;

  typedef enum logic [1:0] {
    HWLP_START = 2'd0,
    HWLP_END   = 2'd1,
    HWLP_CNT   = 2'd2,
    HWLP_NONE  = 2'd3
  } hwlp_field_e;

  localparam int HWLP_WE_START = 0;
  localparam int HWLP_WE_END   = 1;
  localparam int HWLP_WE_CNT   = 2;

  function automatic logic [31:0] hwlp_align_start(input logic [31:0] addr);
    return {addr[31:1], 1'b0};
  endfunction

endpackage

// File: rtl/riscv_hwloop_regs_if.sv
// Write bus from the ID stage into the hardware-loop register file.
interface riscv_hwloop_regs_if #(
  parameter int REGID_W = 1
);
  logic [31:0]        hwlp_start_data;
  logic [31:0]        hwlp_end_data;
  logic [31:0]        hwlp_cnt_data;
  logic [2:0]         hwlp_we;
  logic [REGID_W-1:0] hwlp_regid;
  logic               valid;

  modport master (
    output hwlp_start_data, hwlp_end_data, hwlp_cnt_data, hwlp_we, hwlp_regid, valid
  );

  modport slave (
    input hwlp_start_data, hwlp_end_data, hwlp_cnt_data, hwlp_we, hwlp_regid, valid
  );
endinterface

// File: rtl/riscv_hwloop_reg_entry.sv
// State for a single hardware loop: start, end, counter and decrement-in-flight flag.
module riscv_hwloop_reg_entry
  import riscv_hwloop_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_start_data,
  input  logic [31:0] i_end_data,
  input  logic [31:0] i_cnt_data,
  input  logic        i_we_start,
  input  logic        i_we_end,
  input  logic        i_we_cnt,
  input  logic        i_dec_req,
  input  logic        i_if_ready,
  input  logic        i_id_valid,
  input  logic        i_flush,
  output logic [31:0] o_start,
  output logic [31:0] o_end,
  output logic [31:0] o_cnt,
  output logic        o_dec_id
);

  logic [31:0] r_start;
  logic [31:0] r_end;
  logic [31:0] r_cnt;
  logic        r_dec;
  logic        w_do_dec;

  // A counter write in the same cycle takes precedence and swallows the decrement.
  assign w_do_dec = i_id_valid & r_dec & ~i_flush & (r_cnt != 32'd0) & ~i_we_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start <= 32'd0;
      r_end   <= 32'd0;
      r_cnt   <= 32'd0;
      r_dec   <= 1'b0;
    end else begin
      if (i_we_start) begin
        r_start <= hwlp_align_start(i_start_data);
      end
      if (i_we_end) begin
        r_end <= i_end_data;
      end
      if (i_we_cnt) begin
        r_cnt <= i_cnt_data;
      end else if (w_do_dec) begin
        r_cnt <= r_cnt - 32'd1;
      end
      if (i_flush) begin
        r_dec <= 1'b0;
      end else if (i_if_ready) begin
        r_dec <= i_dec_req;
      end else if (i_id_valid) begin
        r_dec <= 1'b0;
      end
    end
  end

  assign o_start  = r_start;
  assign o_end    = r_end;
  assign o_cnt    = r_cnt;
  assign o_dec_id = r_dec;

endmodule

// File: rtl/riscv_hwloop_regs.sv
// Hardware-loop register file: regid decode, per-loop entries and the combinational read port.
module riscv_hwloop_regs
  import riscv_hwloop_pkg::*;
#(
  parameter int N_REGS  = 2,
  localparam int REGID_W = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  riscv_hwloop_regs_if.slave       hwlp_wr,
  input  logic [N_REGS-1:0]        hwlp_dec_cnt_i,
  input  logic                     if_ready_i,
  input  logic                     id_valid_i,
  input  logic                     flush_i,
  input  logic [REGID_W-1:0]       hwlp_rd_regid_i,
  input  logic [1:0]               hwlp_rd_sel_i,
  output logic [N_REGS-1:0][31:0]  hwlp_start_addr_o,
  output logic [N_REGS-1:0][31:0]  hwlp_end_addr_o,
  output logic [N_REGS-1:0][31:0]  hwlp_counter_o,
  output logic [N_REGS-1:0]        hwlp_dec_cnt_id_o,
  output logic [31:0]              hwlp_rdata_o
);

  logic [N_REGS-1:0] w_hit;
  logic [31:0]       w_rdata;

  for (genvar g = 0; g < N_REGS; g++) begin : g_entry
    // Out-of-range regid never matches any entry, so such writes fall away.
    assign w_hit[g] = hwlp_wr.valid && (32'(hwlp_wr.hwlp_regid) == 32'(g));

    riscv_hwloop_reg_entry u_entry (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_start_data (hwlp_wr.hwlp_start_data),
      .i_end_data   (hwlp_wr.hwlp_end_data),
      .i_cnt_data   (hwlp_wr.hwlp_cnt_data),
      .i_we_start   (w_hit[g] & hwlp_wr.hwlp_we[HWLP_WE_START]),
      .i_we_end     (w_hit[g] & hwlp_wr.hwlp_we[HWLP_WE_END]),
      .i_we_cnt     (w_hit[g] & hwlp_wr.hwlp_we[HWLP_WE_CNT]),
      .i_dec_req    (hwlp_dec_cnt_i[g]),
      .i_if_ready   (if_ready_i),
      .i_id_valid   (id_valid_i),
      .i_flush      (flush_i),
      .o_start      (hwlp_start_addr_o[g]),
      .o_end        (hwlp_end_addr_o[g]),
      .o_cnt        (hwlp_counter_o[g]),
      .o_dec_id     (hwlp_dec_cnt_id_o[g])
    );
  end

  // Read mux over the registered state; same-cycle writes are not bypassed.
  always_comb begin
    w_rdata = 32'd0;
    if (32'(hwlp_rd_regid_i) < 32'(N_REGS)) begin
      case (hwlp_field_e'(hwlp_rd_sel_i))
        HWLP_START: w_rdata = hwlp_start_addr_o[hwlp_rd_regid_i];
        HWLP_END:   w_rdata = hwlp_end_addr_o[hwlp_rd_regid_i];
        HWLP_CNT:   w_rdata = hwlp_counter_o[hwlp_rd_regid_i];
        HWLP_NONE:  w_rdata = 32'd0;
        default:    w_rdata = 32'd0;
      endcase
    end else begin
      w_rdata = 32'd0;
    end
  end

  assign hwlp_rdata_o = w_rdata;

endmodule

// File: tb/tb_riscv_hwloop_regs.sv
// Directed bench for riscv_hwloop_regs (N_REGS=2 main instance, N_REGS=1 instance for range checks).
module tb_riscv_hwloop_regs;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0]  dec_cnt;
  logic        if_ready, id_valid, flush;
  logic        rd_regid;
  logic [1:0]  rd_sel;

  logic [1:0][31:0] start_o, end_o, cnt_o;
  logic [1:0]       dec_id_o;
  logic [31:0]      rdata_o;

  logic [0:0][31:0] s_start_o, s_end_o, s_cnt_o;
  logic [0:0]       s_dec_id_o;
  logic [31:0]      s_rdata_o;

  int n_vec = 0;
  int n_err = 0;

  riscv_hwloop_regs_if #(.REGID_W(1)) wr_if ();

  always #5 clk = ~clk;

  riscv_hwloop_regs #(.N_REGS(2)) dut (
    .clk(clk), .rst_n(rst_n), .hwlp_wr(wr_if),
    .hwlp_dec_cnt_i(dec_cnt), .if_ready_i(if_ready), .id_valid_i(id_valid), .flush_i(flush),
    .hwlp_rd_regid_i(rd_regid), .hwlp_rd_sel_i(rd_sel),
    .hwlp_start_addr_o(start_o), .hwlp_end_addr_o(end_o), .hwlp_counter_o(cnt_o),
    .hwlp_dec_cnt_id_o(dec_id_o), .hwlp_rdata_o(rdata_o)
  );

  riscv_hwloop_regs #(.N_REGS(1)) dut_one (
    .clk(clk), .rst_n(rst_n), .hwlp_wr(wr_if),
    .hwlp_dec_cnt_i(dec_cnt[0]), .if_ready_i(if_ready), .id_valid_i(id_valid), .flush_i(flush),
    .hwlp_rd_regid_i(rd_regid), .hwlp_rd_sel_i(rd_sel),
    .hwlp_start_addr_o(s_start_o), .hwlp_end_addr_o(s_end_o), .hwlp_counter_o(s_cnt_o),
    .hwlp_dec_cnt_id_o(s_dec_id_o), .hwlp_rdata_o(s_rdata_o)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_if.valid = 1'b0; wr_if.hwlp_we = 3'b000;
    dec_cnt = 2'b00; if_ready = 1'b0; id_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic wr(input logic id, input logic [2:0] we,
                    input logic [31:0] s, input logic [31:0] e, input logic [31:0] c);
    wr_if.valid = 1'b1; wr_if.hwlp_regid = id; wr_if.hwlp_we = we;
    wr_if.hwlp_start_data = s; wr_if.hwlp_end_data = e; wr_if.hwlp_cnt_data = c;
  endtask

  task automatic set_flag(input logic [1:0] d);
    idle(); dec_cnt = d; if_ready = 1'b1; step(); idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    wr(1'b0, 3'b000, 32'd0, 32'd0, 32'd0); wr_if.valid = 1'b0;
    rd_regid = 1'b0; rd_sel = 2'd0;
    #12;
    check_vec("rst_start0", start_o[0], 32'd0);
    check_vec("rst_cnt1", cnt_o[1], 32'd0);
    check_vec("rst_dec", {30'd0, dec_id_o}, 32'd0);
    check_vec("rst_rdata", rdata_o, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    step();

    // Full setup of loop 1
    wr(1'b1, 3'b111, 32'h101, 32'h120, 32'd5); step(); idle();
    check_vec("setup_start1", start_o[1], 32'h100);
    check_vec("setup_end1", end_o[1], 32'h120);
    check_vec("setup_cnt1", cnt_o[1], 32'd5);
    check_vec("setup_cnt0", cnt_o[0], 32'd0);
    check_vec("one_oor_end", s_end_o[0], 32'd0);
    wr(1'b1, 3'b111, 32'h200, 32'h300, 32'd7); wr_if.valid = 1'b0; step(); idle();
    check_vec("novalid_end1", end_o[1], 32'h120);
    check_vec("novalid_cnt1", cnt_o[1], 32'd5);

    // Decrement pipeline on loop 0
    wr(1'b0, 3'b100, 32'd0, 32'd0, 32'd3); step(); idle();
    check_vec("cnt0_init", cnt_o[0], 32'd3);
    set_flag(2'b01);
    check_vec("flag_set", {30'd0, dec_id_o}, 32'd1);
    id_valid = 1'b1; step(); idle();
    check_vec("dec_cnt0", cnt_o[0], 32'd2);
    check_vec("dec_flag_clr", {30'd0, dec_id_o}, 32'd0);

    // Flush kills the in-flight decrement
    set_flag(2'b01);
    id_valid = 1'b1; flush = 1'b1; step(); idle();
    check_vec("flush_cnt0", cnt_o[0], 32'd2);
    check_vec("flush_flag", {30'd0, dec_id_o}, 32'd0);

    // Counter write beats decrement
    set_flag(2'b01);
    wr(1'b0, 3'b100, 32'd0, 32'd0, 32'd9); id_valid = 1'b1; step(); idle();
    check_vec("conflict_cnt0", cnt_o[0], 32'd9);
    check_vec("one_cnt0", s_cnt_o[0], 32'd9);

    // End-field write does not block decrement
    set_flag(2'b01);
    wr(1'b0, 3'b010, 32'd0, 32'h55, 32'd0); id_valid = 1'b1; step(); idle();
    check_vec("otherfield_cnt0", cnt_o[0], 32'd8);
    check_vec("otherfield_end0", end_o[0], 32'h55);

    // Both loops decrement together
    set_flag(2'b11);
    check_vec("flag_both", {30'd0, dec_id_o}, 32'd3);
    id_valid = 1'b1; step(); idle();
    check_vec("multi_cnt0", cnt_o[0], 32'd7);
    check_vec("multi_cnt1", cnt_o[1], 32'd4);

    // Saturation at zero
    wr(1'b0, 3'b100, 32'd0, 32'd0, 32'd0); step(); idle();
    set_flag(2'b01);
    id_valid = 1'b1; step(); idle();
    check_vec("sat_cnt0", cnt_o[0], 32'd0);

    // Read port
    rd_regid = 1'b1; rd_sel = 2'd1; #1;
    check_vec("rd_end1", rdata_o, 32'h120);
    check_vec("rd_oor", s_rdata_o, 32'd0);
    rd_sel = 2'd0; #1;
    check_vec("rd_start1", rdata_o, 32'h100);
    rd_sel = 2'd2; #1;
    check_vec("rd_cnt1", rdata_o, 32'd4);
    rd_sel = 2'd3; #1;
    check_vec("rd_none", rdata_o, 32'd0);
    rd_regid = 1'b0; rd_sel = 2'd1; #1;
    check_vec("rd_end0", rdata_o, 32'h55);
    check_vec("one_rd_end0", s_rdata_o, 32'h55);

    // Same-cycle write not bypassed to the read port
    wr(1'b0, 3'b010, 32'd0, 32'h77, 32'd0); #1;
    check_vec("rd_nobypass", rdata_o, 32'h55);
    step(); idle();
    check_vec("rd_after_wr", rdata_o, 32'h77);

    // Asynchronous reset mid-loop
    set_flag(2'b10);
    rd_regid = 1'b1; rd_sel = 2'd2;
    #2 rst_n = 1'b0; #1;
    check_vec("arst_cnt1", cnt_o[1], 32'd0);
    check_vec("arst_end0", end_o[0], 32'd0);
    check_vec("arst_dec", {30'd0, dec_id_o}, 32'd0);
    check_vec("arst_rdata", rdata_o, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
